// File: rtl/sampling_fir_pkg.sv
// Shared widths, default coefficients and FSM encoding for the sampling FIR stage.
package sampling_fir_pkg;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int FIR_TAPS = 8;
  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int ACC_W    = PROD_W + $clog2(FIR_TAPS);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Symmetric Q1.15 low-pass, sums to 0x8000 for unity DC gain.
  localparam coef_t FIR_COEF [FIR_TAPS] = '{
    16'sh0400, 16'sh0C00, 16'sh1400, 16'sh1C00,
    16'sh1C00, 16'sh1400, 16'sh0C00, 16'sh0400
  };

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, MAC, ROUND, OUT} fir_state_t;
endpackage

// File: rtl/sampling_fir_filter_if.sv
// Buffer read side plus filtered-sample output port of the FIR stage.
interface sampling_fir_filter_if;
  import sampling_fir_pkg::*;

  sample_t Sampling_Q;
  logic    Sampling_Empty;
  logic    Sampling_Read_en;
  sample_t Fir_Q;
  logic    Fir_Valid;
  logic    Fir_Ready;

  modport master (
    input  Sampling_Q, Sampling_Empty, Fir_Ready,
    output Sampling_Read_en, Fir_Q, Fir_Valid
  );
  modport slave (
    output Sampling_Q, Sampling_Empty, Fir_Ready,
    input  Sampling_Read_en, Fir_Q, Fir_Valid
  );
endinterface

// File: rtl/sampling_fir_mac.sv
// Registered 16x16 signed multiply feeding a 35-bit accumulator; acc_sum already includes the
// product in flight, so it is final the cycle after the last enable. No backpressure.
module sampling_fir_mac
  import sampling_fir_pkg::*;
(
  input  logic    Clk,
  input  logic    Rst_n,
  input  logic    clr,
  input  logic    en,
  input  sample_t a,
  input  coef_t   b,
  output acc_t    acc_sum
);
  prod_t prod_q, prod_d;
  logic  prod_vld_q, prod_vld_d;
  acc_t  acc_q, acc_d;

  assign acc_sum = acc_q + (prod_vld_q ? acc_t'(prod_q) : acc_t'(0));

  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_sum;
    if (en) begin
      prod_d     = a * b;
      prod_vld_d = 1'b1;
    end
    if (clr) begin
      prod_d     = '0;
      prod_vld_d = 1'b0;
      acc_d      = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
  end
endmodule

// File: rtl/sampling_fir_filter.sv
// TAPS-tap FIR after the sampling buffer: Fir_Valid rises TAPS+3 cycles after the read pulse; no
// read is issued until the result is accepted. FIR_SATURATE_EN clamps instead of wrapping.
module sampling_fir_filter
  import sampling_fir_pkg::*;
#(
  parameter int TAPS     = FIR_TAPS,
  parameter int GAIN_SHL = 0
) (
  input logic                   Clk,
  input logic                   Rst_n,
  input logic                   Fir_Clear,
  sampling_fir_filter_if.master bus
);
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(TAPS - 1);

  fir_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  sample_t       tap_q [TAPS];
  sample_t       tap_d [TAPS];
  sample_t       fir_q_q, fir_q_d;
  logic          fir_valid_q, fir_valid_d;
  logic          read_en_q, read_en_d;
  logic          mac_clr, mac_en;
  acc_t          mac_acc, rnd;
  sample_t       result;

  sampling_fir_mac u_mac (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (tap_q[idx_q]),
    .b       (FIR_COEF[idx_q]),
    .acc_sum (mac_acc)
  );

`ifdef FIR_SATURATE_EN
  localparam acc_t SAT_MAX = acc_t'(32767);
  localparam acc_t SAT_MIN = -acc_t'(32768);
  acc_t shf;
`endif

  always_comb begin
    result = '0;
    rnd    = (mac_acc + acc_t'(1 << 14)) >>> 15;
`ifdef FIR_SATURATE_EN
    shf = rnd <<< GAIN_SHL;
    if (shf > SAT_MAX)      result = 16'sh7FFF;
    else if (shf < SAT_MIN) result = 16'sh8000;
    else                    result = sample_t'(shf);
`else
    result = sample_t'(rnd <<< GAIN_SHL);
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tap_d   = tap_q;
    fir_q_d = fir_q_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      IDLE:    if (!bus.Sampling_Empty) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        tap_d[0] = bus.Sampling_Q;
        for (int k = 1; k < TAPS; k++) tap_d[k] = tap_q[k-1];
        mac_clr = 1'b1;
        idx_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx_q == IDX_LAST) state_d = ROUND;
        else                   idx_d   = idx_q + 1'b1;
      end
      ROUND: begin
        fir_q_d = result;
        state_d = OUT;
      end
      OUT:     if (bus.Fir_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear wins over everything, including a sample being captured this cycle.
    if (Fir_Clear) begin
      state_d = IDLE;
      tap_d   = '{default: '0};
      idx_d   = '0;
      mac_clr = 1'b1;
    end
    read_en_d   = (state_d == READ);
    fir_valid_d = (state_d == OUT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tap_q       <= '{default: '0};
      fir_q_q     <= '0;
      fir_valid_q <= 1'b0;
      read_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tap_q       <= tap_d;
      fir_q_q     <= fir_q_d;
      fir_valid_q <= fir_valid_d;
      read_en_q   <= read_en_d;
    end
  end

  assign bus.Sampling_Read_en = read_en_q;
  assign bus.Fir_Q            = fir_q_q;
  assign bus.Fir_Valid        = fir_valid_q;
endmodule

// File: tb/tb_sampling_fir_filter.sv
// Bench for sampling_fir_filter: gain-0 and gain-1 instances run in lockstep from one emulated
// buffer; results are compared with a sample-history model of the filter.
module tb_sampling_fir_filter;
  logic Clk;
  logic Rst_n;
  logic Fir_Clear;

  sampling_fir_filter_if bus0 ();
  sampling_fir_filter_if bus1 ();

  assign bus1.Sampling_Q     = bus0.Sampling_Q;
  assign bus1.Sampling_Empty = bus0.Sampling_Empty;
  assign bus1.Fir_Ready      = bus0.Fir_Ready;

  sampling_fir_filter #(.TAPS(8), .GAIN_SHL(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Fir_Clear(Fir_Clear), .bus(bus0));
  sampling_fir_filter #(.TAPS(8), .GAIN_SHL(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Fir_Clear(Fir_Clear), .bus(bus1));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int          n_checks, n_fail, cyc, t_rd, exp_rd_cyc, rdy_mode;
  bit          lat_armed, prev_valid, force_empty;
  logic [15:0] src_q[$];
  logic [15:0] exp0[$], exp1[$], got0[$], got1[$];
  longint      hist[8];
  longint      coef[8] = '{1024, 3072, 5120, 7168, 7168, 5120, 3072, 1024};

  function automatic logic [15:0] model_out(input longint acc, input int shl);
    longint r;
    r = (acc + 16384) >>> 15;
    r = r * (longint'(1) << shl);
`ifdef FIR_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic push_model(input logic [15:0] s);
    longint acc;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(s));
    acc = 0;
    for (int k = 0; k < 8; k++) acc += hist[k] * coef[k];
    exp0.push_back(model_out(acc, 0));
    exp1.push_back(model_out(acc, 1));
  endtask

  task automatic flush_model();
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    lat_armed  = 1'b0;
    exp_rd_cyc = 0;
  endtask

  // One clock: drive ready for the coming edge, score any transfer, act as the buffer.
  task automatic cycle();
    logic [15:0] s, e0, e1;
    @(negedge Clk);
    cyc++;
    if (bus0.Fir_Valid && !prev_valid && lat_armed) begin
      n_checks++;
      if (cyc - t_rd != 11) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles, want 11", cyc - t_rd);
      end
      lat_armed = 1'b0;
    end
    prev_valid = bus0.Fir_Valid;
    case (rdy_mode)
      0:       bus0.Fir_Ready = 1'b1;
      1:       bus0.Fir_Ready = ($urandom_range(0, 3) != 0);
      default: bus0.Fir_Ready = 1'b0;
    endcase
    if (bus0.Fir_Valid && bus0.Fir_Ready) begin
      n_checks++;
      if (exp0.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, want no output", bus0.Fir_Q);
      end else begin
        e0 = exp0.pop_front();
        e1 = exp1.pop_front();
        if (bus0.Fir_Q !== e0) begin
          n_fail++;
          $display("FAIL out_gain0: got %h, want %h", bus0.Fir_Q, e0);
        end
        n_checks++;
        if (bus1.Fir_Q !== e1) begin
          n_fail++;
          $display("FAIL out_gain1: got %h, want %h", bus1.Fir_Q, e1);
        end
        got0.push_back(bus0.Fir_Q);
        got1.push_back(bus1.Fir_Q);
      end
      exp_rd_cyc = (src_q.size() > 0) ? cyc + 2 : 0;
    end
    if (bus0.Sampling_Read_en === 1'b1) begin
      if (exp_rd_cyc != 0) begin
        n_checks++;
        if (cyc != exp_rd_cyc) begin
          n_fail++;
          $display("FAIL read_gap: read at cycle %0d, want %0d", cyc, exp_rd_cyc);
        end
        exp_rd_cyc = 0;
      end
      n_checks++;
      if (src_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_while_empty: got read pulse, want none");
      end else begin
        s = src_q.pop_front();
        bus0.Sampling_Q = s;
        push_model(s);
      end
      t_rd      = cyc;
      lat_armed = 1'b1;
    end
    bus0.Sampling_Empty = force_empty || (src_q.size() == 0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((src_q.size() > 0 || exp0.size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (src_q.size() > 0 || exp0.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d inputs and %0d results left, want 0", src_q.size(), exp0.size());
    end
    repeat (2) cycle();
  endtask

  task automatic wait_read(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      cycle();
      seen = bus0.Sampling_Read_en;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL read_timeout: got no read pulse in 50 cycles, want one");
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Fir_Clear = 1'b0;
    bus0.Sampling_Q = '0;
    bus0.Sampling_Empty = 1'b1;
    bus0.Fir_Ready = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks += 3;
    if (bus0.Fir_Q !== 16'h0000 || bus1.Fir_Q !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_q: got %h/%h, want 0000", bus0.Fir_Q, bus1.Fir_Q);
    end
    if (bus0.Fir_Valid !== 1'b0 || bus1.Fir_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b/%b, want 0", bus0.Fir_Valid, bus1.Fir_Valid);
    end
    if (bus0.Sampling_Read_en !== 1'b0 || bus1.Sampling_Read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read: got %b/%b, want 0", bus0.Sampling_Read_en, bus1.Sampling_Read_en);
    end
    Rst_n = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_impulse();
    logic [15:0] imp [8] = '{16'h0400, 16'h0C00, 16'h1400, 16'h1C00,
                             16'h1C00, 16'h1400, 16'h0C00, 16'h0400};
    got0.delete();
    rdy_mode = 0;
    src_q.push_back(16'h7FFF);
    repeat (7) src_q.push_back(16'h0000);
    drain(300);
    n_checks++;
    if (got0.size() != 8) begin
      n_fail++;
      $display("FAIL impulse_count: got %0d outputs, want 8", got0.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0) n_checks++;
        if (got0[k] !== imp[k]) begin
          n_fail++;
          $display("FAIL impulse_tap%0d: got %h, want %h", k, got0[k], imp[k]);
        end
      end
    end
  endtask

  task automatic test_dc();
    got0.delete();
    rdy_mode = 0;
    repeat (16) src_q.push_back(16'h1000);
    drain(400);
    n_checks++;
    if (got0.size() != 16) begin
      n_fail++;
      $display("FAIL dc_count: got %0d outputs, want 16", got0.size());
    end else begin
      for (int k = 7; k < 16; k++) begin
        if (k > 7) n_checks++;
        if (got0[k] !== 16'h1000) begin
          n_fail++;
          $display("FAIL dc_out%0d: got %h, want 1000", k, got0[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] want1;
`ifdef FIR_SATURATE_EN
    want1 = 16'h7FFF;
`else
    want1 = 16'hA000;
`endif
    got0.delete();
    got1.delete();
    rdy_mode = 0;
    repeat (12) src_q.push_back(16'h5000);
    drain(300);
    n_checks += 2;
    if (got1.size() == 0 || got1[got1.size()-1] !== want1) begin
      n_fail++;
      $display("FAIL overflow_gain1: got %h, want %h", (got1.size() > 0) ? got1[got1.size()-1] : 16'hxxxx, want1);
    end
    if (got0.size() == 0 || got0[got0.size()-1] !== 16'h5000) begin
      n_fail++;
      $display("FAIL overflow_gain0: got %h, want 5000", (got0.size() > 0) ? got0[got0.size()-1] : 16'hxxxx);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    bit up;
    rdy_mode = 2;
    src_q.push_back(16'($urandom));
    src_q.push_back(16'($urandom));
    up = 1'b0;
    for (int k = 0; k < 40 && !up; k++) begin
      cycle();
      up = bus0.Fir_Valid;
    end
    n_checks++;
    if (!up) begin
      n_fail++;
      $display("FAIL bp_valid_timeout: got no Fir_Valid, want one");
    end
    held = bus0.Fir_Q;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (bus0.Fir_Q !== held || bus0.Fir_Valid !== 1'b1 || bus0.Sampling_Read_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: got q=%h vld=%b rd=%b, want q=%h vld=1 rd=0",
                 bus0.Fir_Q, bus0.Fir_Valid, bus0.Sampling_Read_en, held);
      end
    end
    rdy_mode = 0;
    cycle();
    cycle();
    n_checks++;
    if (bus0.Fir_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_valid_fall: got %b after accept, want 0", bus0.Fir_Valid);
    end
    drain(200);
  endtask

  task automatic test_empty();
    int rd_cnt, vld_cnt;
    rd_cnt = 0;
    vld_cnt = 0;
    force_empty = 1'b1;
    repeat (3) src_q.push_back(16'($urandom));
    repeat (20) begin
      cycle();
      if (bus0.Sampling_Read_en) rd_cnt++;
      if (bus0.Fir_Valid) vld_cnt++;
    end
    n_checks++;
    if (rd_cnt != 0 || vld_cnt != 0) begin
      n_fail++;
      $display("FAIL empty_hold: got %0d reads %0d valids, want 0 0", rd_cnt, vld_cnt);
    end
    force_empty = 1'b0;
    drain(200);
  endtask

  task automatic test_random();
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) src_q.push_back(16'($urandom));
      repeat ($urandom_range(1, 20)) cycle();
    end
    drain(4000);
    rdy_mode = 0;
  endtask

  task automatic test_clear(input bit use_reset);
    bit seen;
    int vld_cnt;
    rdy_mode = 0;
    src_q.push_back(16'h7FFF);
    wait_read(seen);
    repeat (4) cycle();
    // Now in the third MAC cycle of that sample.
    if (use_reset) begin
      Rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus0.Fir_Q !== 16'h0000 || bus0.Fir_Valid !== 1'b0 || bus0.Sampling_Read_en !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_outputs: got q=%h vld=%b rd=%b, want 0000 0 0",
                 bus0.Fir_Q, bus0.Fir_Valid, bus0.Sampling_Read_en);
      end
      cycle();
      Rst_n = 1'b1;
    end else begin
      Fir_Clear = 1'b1;
      cycle();
      Fir_Clear = 1'b0;
    end
    flush_model();
    vld_cnt = 0;
    repeat (15) begin
      cycle();
      if (bus0.Fir_Valid || bus1.Fir_Valid) vld_cnt++;
    end
    n_checks++;
    if (vld_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_output: got %0d valid cycles, want 0", vld_cnt);
    end
    test_impulse();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: still running at %0t, want finish", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    t_rd = 0;
    exp_rd_cyc = 0;
    rdy_mode = 0;
    lat_armed = 1'b0;
    prev_valid = 1'b0;
    force_empty = 1'b0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    test_reset();
    test_impulse();
    test_dc();
    test_overflow();
    test_backpressure();
    test_empty();
    test_random();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
